tube_responder: RTL and testbench
=================================

// Module: tube_responder
// PURPOSE
//  Parasite-side Tube register responder: the far end of the CPC host Tube bridge.
//  - Services host cycles on TUBE_CS_B/TUBE_RNW_B/TUBE_PHI2/TUBE_ADR/TUBE_DATA.
//  - Provides four byte channels (R1-R4): host-to-parasite (H2P) and parasite-to-host (P2H).
//  - Oversamples the host strobes with the single system clock.
//  - Presents simple pulse/level handshakes to the parasite CPU glue.
// PARAMETERS
//  R1_DEPTH   4   P2H FIFO depth for channel 0 (R1); power of two, >=2. Channels 1-3 P2H are depth 1.
//  SYNC_STG   2   Synchroniser flops on TUBE_PHI2, TUBE_CS_B, TUBE_RNW_B, TUBE_RST_B (2 or 3).
// PORTS
//  CLK         in   1   System clock. Must be >=4x TUBE_PHI2 frequency.
//  RESET       in   1   Synchronous, active-high reset.
//  TUBE_PHI2   in   1   Host bus phase-2 strobe.
//  TUBE_CS_B   in   1   Host chip select, active low.
//  TUBE_RNW_B  in   1   1 = host read, 0 = host write.
//  TUBE_ADR    in   3   [2:1] = channel, [0] = 0 status / 1 data.
//  TUBE_DATA   inout 8  Host data; driven only during a qualified host read.
//  TUBE_RST_B  in   1   Host-requested parasite reset, active low.
//  TUBE_INT_B  out  1   Host interrupt, active low.
//  PAR_RST     out  1   Synchronised reset to parasite: RESET | !TUBE_RST_B(synced).
//  P2H_WR      in   4   One-hot write strobe per channel; 1 clock per byte.
//  P2H_DATA    in   8   Byte written with P2H_WR.
//  P2H_SPACE   out  4   Channel n P2H can accept a byte.
//  H2P_AVAIL   out  4   Channel n holds a host byte.
//  H2P_DATA    out  32  Packed H2P bytes; channel n = [8n+7:8n].
//  H2P_ACK     in   4   Parasite consumes channel n byte; 1 clock.
//  OVERRUN     out  1   Sticky: host wrote to a full H2P channel.
// BEHAVIOUR
//  Reset:
//   - On RESET, or on synced TUBE_RST_B low: all FIFOs empty, P2H_SPACE=4'hF, H2P_AVAIL=0,
//     H2P_DATA=0, OVERRUN=0, TUBE_INT_B=1, TUBE_DATA=Z, read-hold register = 8'h00.
//  Host cycle qualification:
//   - Edge detect = synced PHI2 1->0 while synced CS_B=0.
//   - Fires once per host cycle, SYNC_STG+1 clocks after the raw falling edge.
//  Host read drive:
//   - TUBE_DATA driven combinationally whenever raw PHI2=1 & CS_B=0 & RNW_B=1; otherwise Z.
//   - Status addr (ADR[0]=0): {P2H nonempty, H2P not full, 6'b0} for channel ADR[2:1].
//   - Data addr: P2H head of channel ADR[2:1] if nonempty, else the read-hold register.
//  Host read commit:
//   - On the edge detect with synced RNW_B=1 and data addr, pop the channel if nonempty.
//   - Popped byte is copied to read-hold. Pop on empty has no effect.
//   - Status reads never pop.
//  Host write:
//   - Capture register samples raw TUBE_DATA every CLK in which raw PHI2=1 & CS_B=0 & RNW_B=0.
//   - On the edge detect with synced RNW_B=0 and data addr, the captured byte enters H2P.
//   - If the channel is full, the byte is dropped and OVERRUN is set.
//   - Writes to status addresses are ignored.
//  Latency:
//   - P2H_WR at cycle N: status bit7 / data visible at N+1.
//   - Host commit at N: H2P_AVAIL at N+1.
//   - H2P_ACK at N: status bit6 at N+1.
//  P2H FIFO (channel 0):
//   - Pointers are log2(R1_DEPTH)+1 bits and wrap naturally.
//   - P2H_SPACE[0] = !full. P2H_WR when full is ignored, even if a host pop is in the same cycle.
//   - Write and pop in the same cycle: both take effect; count is unchanged.
//   - Write to empty with simultaneous pop: the pop does not apply (data was not presented).
//  Depth-1 channels: same rules, with full = occupied.
//  H2P_ACK on an empty channel: ignored.
//  TUBE_INT_B = 0 iff channel 3 (R4) P2H nonempty. Registered; changes 1 clock after the FIFO state.
//  Host FSM per cycle: IDLE -> ACTIVE (synced CS_B=0 & PHI2=1) -> COMMIT (edge detect, 1 clock) -> IDLE.
//   - CS_B rising without a PHI2 fall: ACTIVE -> IDLE, no commit.
//  Reset mid-cycle: FSM -> IDLE; no commit for that cycle; TUBE_DATA released.
// TESTING
//  - P2H_WR[0] with 8'h41, then host read of ADR=1 -> TUBE_DATA=8'h41 during PHI2; then ADR=0 reads 8'h40.
//  - Four P2H_WR[0] with 1,2,3,4 -> P2H_SPACE[0]=0; a 5th write (8'h55) is dropped; four host reads return 1,2,3,4.
//  - Host writes 8'hA5 to ADR=3 -> H2P_AVAIL=4'b0010, H2P_DATA[15:8]=8'hA5; a second write sets OVERRUN;
//    H2P_ACK[1] clears AVAIL.
//  - P2H_WR[3] with 8'h07 -> TUBE_INT_B=0 next clock; host read of ADR=7 -> TUBE_INT_B=1; re-read returns 8'h07 (hold).
//  - TUBE_RST_B low for 3 PHI2 cycles with full FIFOs -> PAR_RST=1, all FIFOs empty, OVERRUN=0.
//  - RESET asserted while PHI2 high in a host write -> no H2P entry; TUBE_DATA stays Z.

Source files
------------

// File: rtl/tube_responder.sv
// Parasite-side Tube register responder: services host bus cycles and moves bytes
// across four channels between the host and the parasite CPU glue.
module tube_responder #(
  parameter int R1_DEPTH = 4,
  parameter int SYNC_STG = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TUBE_PHI2,
  input  logic        TUBE_CS_B,
  input  logic        TUBE_RNW_B,
  input  logic [2:0]  TUBE_ADR,
  inout  wire  [7:0]  TUBE_DATA,
  input  logic        TUBE_RST_B,
  output logic        TUBE_INT_B,
  output logic        PAR_RST,
  input  logic [3:0]  P2H_WR,
  input  logic [7:0]  P2H_DATA,
  output logic [3:0]  P2H_SPACE,
  output logic [3:0]  H2P_AVAIL,
  output logic [31:0] H2P_DATA,
  input  logic [3:0]  H2P_ACK,
  output logic        OVERRUN
);
  localparam int AW = $clog2(R1_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} host_state_t;

  logic [SYNC_STG-1:0] phi2_sync, cs_sync, rnw_sync, rst_sync;
  logic                phi2_s, cs_s, rnw_s, rst_s, int_rst;
  host_state_t         state;
  logic                block;
  logic                com_rnw;
  logic [2:0]          com_adr, adr_cap;
  logic [7:0]          wr_cap;
  logic [3:0]          host_pop, host_push;
  logic [7:0]          r1_mem [R1_DEPTH];
  logic [AW:0]         r1_wp, r1_rp;
  logic [3:1]          occ;
  logic [7:0]          p2h_reg [1:3];
  logic [3:0]          p2h_full, p2h_nonempty, p2h_wr_ok, p2h_pop_ok;
  logic [7:0]          p2h_head [4];
  logic [7:0]          rd_hold, rd_data;
  logic [3:0]          h2p_avail;
  logic [7:0]          h2p_byte [4];
  logic                drive;

  // Host strobe synchronisers
  always_ff @(posedge CLK) begin
    phi2_sync <= {phi2_sync[SYNC_STG-2:0], TUBE_PHI2};
    cs_sync   <= {cs_sync[SYNC_STG-2:0], TUBE_CS_B};
    rnw_sync  <= {rnw_sync[SYNC_STG-2:0], TUBE_RNW_B};
    rst_sync  <= {rst_sync[SYNC_STG-2:0], TUBE_RST_B};
  end

  assign phi2_s  = phi2_sync[SYNC_STG-1];
  assign cs_s    = cs_sync[SYNC_STG-1];
  assign rnw_s   = rnw_sync[SYNC_STG-1];
  assign rst_s   = rst_sync[SYNC_STG-1];
  assign int_rst = RESET | ~rst_s;
  assign PAR_RST = int_rst;

  // Raw-domain capture while the host strobe is asserted
  always_ff @(posedge CLK) begin
    if (TUBE_PHI2 && !TUBE_CS_B) begin
      adr_cap <= TUBE_ADR;
      if (!TUBE_RNW_B) wr_cap <= TUBE_DATA;
    end
  end

  // Host cycle FSM; block keeps a cycle interrupted by reset from committing
  // until PHI2 has been seen low all the way through the synchroniser.
  always_ff @(posedge CLK) begin
    if (int_rst) begin
      state <= IDLE;
      block <= 1'b1;
    end else begin
      if (!TUBE_PHI2 && (phi2_sync == '0)) block <= 1'b0;
      case (state)
        IDLE:    if (!block && !cs_s && phi2_s) state <= ACTIVE;
        ACTIVE: begin
          if (cs_s) begin
            state <= IDLE;
          end else if (!phi2_s) begin
            state   <= COMMIT;
            com_rnw <= rnw_s;
            com_adr <= adr_cap;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    host_pop  = '0;
    host_push = '0;
    if (state == COMMIT && com_adr[0]) begin
      if (com_rnw) host_pop[com_adr[2:1]]  = 1'b1;
      else         host_push[com_adr[2:1]] = 1'b1;
    end
  end

  always_comb begin
    p2h_full[0]     = (r1_wp[AW] != r1_rp[AW]) && (r1_wp[AW-1:0] == r1_rp[AW-1:0]);
    p2h_nonempty[0] = (r1_wp != r1_rp);
    p2h_head[0]     = r1_mem[r1_rp[AW-1:0]];
    for (int n = 1; n < 4; n++) begin
      p2h_full[n]     = occ[n];
      p2h_nonempty[n] = occ[n];
      p2h_head[n]     = p2h_reg[n];
    end
  end

  // A pop needs data already present, so write-to-empty plus pop only writes.
  assign p2h_wr_ok  = P2H_WR & ~p2h_full;
  assign p2h_pop_ok = host_pop & p2h_nonempty;

  always_ff @(posedge CLK) begin
    if (p2h_wr_ok[0]) r1_mem[r1_wp[AW-1:0]] <= P2H_DATA;
    for (int n = 1; n < 4; n++)
      if (p2h_wr_ok[n]) p2h_reg[n] <= P2H_DATA;
  end

  always_ff @(posedge CLK) begin
    if (int_rst) begin
      r1_wp      <= '0;
      r1_rp      <= '0;
      occ        <= '0;
      rd_hold    <= 8'h00;
      TUBE_INT_B <= 1'b1;
    end else begin
      if (p2h_wr_ok[0])  r1_wp <= r1_wp + 1'b1;
      if (p2h_pop_ok[0]) r1_rp <= r1_rp + 1'b1;
      for (int n = 1; n < 4; n++) begin
        if (p2h_wr_ok[n])       occ[n] <= 1'b1;
        else if (p2h_pop_ok[n]) occ[n] <= 1'b0;
      end
      if (|p2h_pop_ok) rd_hold <= p2h_head[com_adr[2:1]];
      TUBE_INT_B <= ~occ[3];
    end
  end

  always_ff @(posedge CLK) begin
    if (int_rst) begin
      h2p_avail <= '0;
      OVERRUN   <= 1'b0;
      for (int n = 0; n < 4; n++) h2p_byte[n] <= 8'h00;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (host_push[n] && !h2p_avail[n]) begin
          h2p_avail[n] <= 1'b1;
          h2p_byte[n]  <= wr_cap;
        end else if (H2P_ACK[n]) begin
          h2p_avail[n] <= 1'b0;
        end
      end
      if (|(host_push & h2p_avail)) OVERRUN <= 1'b1;
    end
  end

  always_comb begin
    if (TUBE_ADR[0])
      rd_data = p2h_nonempty[TUBE_ADR[2:1]] ? p2h_head[TUBE_ADR[2:1]] : rd_hold;
    else
      rd_data = {p2h_nonempty[TUBE_ADR[2:1]], ~h2p_avail[TUBE_ADR[2:1]], 6'b0};
  end

  assign drive     = TUBE_PHI2 & ~TUBE_CS_B & TUBE_RNW_B & ~int_rst;
  assign TUBE_DATA = drive ? rd_data : 8'hzz;
  assign P2H_SPACE = ~p2h_full;
  assign H2P_AVAIL = h2p_avail;
  assign H2P_DATA  = {h2p_byte[3], h2p_byte[2], h2p_byte[1], h2p_byte[0]};
endmodule

// File: tb/tb_tube_responder.sv
// Bench for tube_responder: queue-based channel model checked every cycle,
// plus directed host/parasite scenarios with literal expectations.
module tb_tube_responder;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        PHI2 = 1'b0, CS_B = 1'b1, RNW_B = 1'b1, RST_B = 1'b1;
  logic [2:0]  ADR = 3'd0;
  wire  [7:0]  TUBE_DATA;
  logic        den = 1'b0;
  logic [7:0]  dout = 8'h00;
  logic        INT_B, PAR_RST, OVERRUN;
  logic [3:0]  P2H_WR = 4'h0, P2H_SPACE, H2P_AVAIL, H2P_ACK = 4'h0;
  logic [7:0]  P2H_DATA = 8'h00;
  logic [31:0] H2P_DATA;

  assign TUBE_DATA = den ? dout : 8'hzz;

  tube_responder #(.R1_DEPTH(4), .SYNC_STG(2)) dut (
    .CLK(CLK), .RESET(RESET), .TUBE_PHI2(PHI2), .TUBE_CS_B(CS_B), .TUBE_RNW_B(RNW_B),
    .TUBE_ADR(ADR), .TUBE_DATA(TUBE_DATA), .TUBE_RST_B(RST_B), .TUBE_INT_B(INT_B),
    .PAR_RST(PAR_RST), .P2H_WR(P2H_WR), .P2H_DATA(P2H_DATA), .P2H_SPACE(P2H_SPACE),
    .H2P_AVAIL(H2P_AVAIL), .H2P_DATA(H2P_DATA), .H2P_ACK(H2P_ACK), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails = 0;
  logic chk_en = 1'b0;
  logic int_exp = 1'b1;

  // Model: P2H byte queues, H2P single-byte slots, sticky overrun, read-hold byte
  logic [7:0] mq [4][$];
  logic [3:0] m_avail = 4'h0;
  logic [7:0] m_h2p [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       m_ovr = 1'b0;
  logic [7:0] m_hold = 8'h00;

  function automatic int cap(input int n);
    return (n == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < 4; n++) begin
      mq[n].delete();
      m_h2p[n] = 8'h00;
    end
    m_avail = 4'h0;
    m_ovr   = 1'b0;
    m_hold  = 8'h00;
  endtask

  always @(negedge CLK) begin : cmp_proc
    logic [3:0] sp;
    if (chk_en) begin
      for (int n = 0; n < 4; n++) sp[n] = (mq[n].size() < cap(n));
      chk("p2h_space", 32'(P2H_SPACE), 32'(sp));
      chk("h2p_avail", 32'(H2P_AVAIL), 32'(m_avail));
      chk("h2p_data", H2P_DATA, {m_h2p[3], m_h2p[2], m_h2p[1], m_h2p[0]});
      chk("overrun", 32'(OVERRUN), 32'(m_ovr));
      chk("int_b", 32'(INT_B), 32'(int_exp));
      chk("par_rst", 32'(PAR_RST), 32'h0);
    end
    int_exp = (mq[3].size() == 0);
  end

  task automatic p2h_wr(input int ch, input logic [7:0] d);
    @(negedge CLK);
    P2H_WR = 4'(1 << ch);
    P2H_DATA = d;
    @(posedge CLK); #1;
    P2H_WR = 4'h0;
    if (mq[ch].size() < cap(ch)) mq[ch].push_back(d);
  endtask

  task automatic h2p_ack(input int ch);
    @(negedge CLK);
    H2P_ACK = 4'(1 << ch);
    @(posedge CLK); #1;
    H2P_ACK = 4'h0;
    m_avail[ch] = 1'b0;
  endtask

  task automatic host_cycle(input logic rnw, input logic [2:0] adr, input logic [7:0] wd,
                            output logic [7:0] rd);
    int ch;
    logic [7:0] exp;
    ch = int'(adr[2:1]);
    @(negedge CLK);
    CS_B = 1'b0; ADR = adr; RNW_B = rnw; PHI2 = 1'b1;
    if (!rnw) begin den = 1'b1; dout = wd; end
    @(posedge CLK); @(posedge CLK); #1;
    rd = TUBE_DATA;
    if (rnw) begin
      if (adr[0]) exp = (mq[ch].size() > 0) ? mq[ch][0] : m_hold;
      else        exp = {mq[ch].size() > 0, !m_avail[ch], 6'b0};
      chk("host_read", 32'(rd), 32'(exp));
    end
    @(negedge CLK);
    PHI2 = 1'b0; den = 1'b0;
    repeat (3) @(posedge CLK);
    @(posedge CLK); #1;
    if (adr[0]) begin
      if (rnw) begin
        if (mq[ch].size() > 0) m_hold = mq[ch].pop_front();
      end else if (m_avail[ch]) begin
        m_ovr = 1'b1;
      end else begin
        m_avail[ch] = 1'b1;
        m_h2p[ch] = wd;
      end
    end
    @(negedge CLK);
    CS_B = 1'b1; RNW_B = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    repeat (3) @(posedge CLK); #1;
    chk("rst_space", 32'(P2H_SPACE), 32'hF);
    chk("rst_avail", 32'(H2P_AVAIL), 32'h0);
    chk("rst_h2p_data", H2P_DATA, 32'h0);
    chk("rst_overrun", 32'(OVERRUN), 32'h0);
    chk("rst_int_b", 32'(INT_B), 32'h1);
    chk("rst_par_rst", 32'(PAR_RST), 32'h1);
    @(negedge CLK); RESET = 1'b0;
    repeat (3) @(posedge CLK); #1;
    chk_en = 1'b1;

    // Single byte P2H on R1, then data and status reads
    p2h_wr(0, 8'h41);
    host_cycle(1'b1, 3'd1, 8'h00, rd);
    chk("t1_data", 32'(rd), 32'h41);
    host_cycle(1'b1, 3'd0, 8'h00, rd);
    chk("t1_status", 32'(rd), 32'h40);

    // Fill R1, overflow write dropped, drain in order, read empty returns hold
    for (int i = 1; i <= 4; i++) p2h_wr(0, 8'(i));
    chk("t2_full", 32'(P2H_SPACE[0]), 32'h0);
    p2h_wr(0, 8'h55);
    for (int i = 1; i <= 4; i++) begin
      host_cycle(1'b1, 3'd1, 8'h00, rd);
      chk("t2_drain", 32'(rd), 32'(i));
    end
    chk("t2_space", 32'(P2H_SPACE[0]), 32'h1);
    host_cycle(1'b1, 3'd1, 8'h00, rd);
    chk("t2_empty_hold", 32'(rd), 32'h04);

    // H2P on R2: write, status, overrun, ack, status-address write ignored
    host_cycle(1'b0, 3'd3, 8'hA5, rd);
    chk("t3_avail", 32'(H2P_AVAIL), 32'h2);
    chk("t3_byte", 32'(H2P_DATA[15:8]), 32'hA5);
    host_cycle(1'b1, 3'd2, 8'h00, rd);
    chk("t3_status_full", 32'(rd), 32'h00);
    host_cycle(1'b0, 3'd3, 8'h5A, rd);
    chk("t3_overrun", 32'(OVERRUN), 32'h1);
    chk("t3_byte_kept", 32'(H2P_DATA[15:8]), 32'hA5);
    h2p_ack(1);
    chk("t3_ack", 32'(H2P_AVAIL), 32'h0);
    host_cycle(1'b1, 3'd2, 8'h00, rd);
    chk("t3_status_room", 32'(rd), 32'h40);
    host_cycle(1'b0, 3'd4, 8'h99, rd);
    chk("t3_status_wr", 32'(H2P_AVAIL), 32'h0);
    h2p_ack(2);

    // R4 interrupt and read-hold
    p2h_wr(3, 8'h07);
    @(posedge CLK); #1;
    chk("t4_int_low", 32'(INT_B), 32'h0);
    host_cycle(1'b1, 3'd7, 8'h00, rd);
    chk("t4_read", 32'(rd), 32'h07);
    @(posedge CLK); #1;
    chk("t4_int_high", 32'(INT_B), 32'h1);
    host_cycle(1'b1, 3'd7, 8'h00, rd);
    chk("t4_hold", 32'(rd), 32'h07);

    // Host-requested reset with everything full
    for (int i = 0; i < 4; i++) p2h_wr(0, 8'(8'h10 + i));
    p2h_wr(1, 8'h21);
    p2h_wr(2, 8'h22);
    p2h_wr(3, 8'h23);
    host_cycle(1'b0, 3'd1, 8'h31, rd);
    host_cycle(1'b0, 3'd1, 8'h32, rd);
    chk("t5_pre_space", 32'(P2H_SPACE), 32'h0);
    chk("t5_pre_ovr", 32'(OVERRUN), 32'h1);
    @(posedge CLK); #1;
    chk_en = 1'b0;
    @(negedge CLK); RST_B = 1'b0;
    repeat (3) begin
      @(negedge CLK); PHI2 = 1'b1;
      repeat (2) @(negedge CLK);
      PHI2 = 1'b0;
      repeat (2) @(negedge CLK);
    end
    @(posedge CLK); #1;
    model_clear();
    chk("t5_par_rst", 32'(PAR_RST), 32'h1);
    chk("t5_space", 32'(P2H_SPACE), 32'hF);
    chk("t5_avail", 32'(H2P_AVAIL), 32'h0);
    chk("t5_h2p_data", H2P_DATA, 32'h0);
    chk("t5_overrun", 32'(OVERRUN), 32'h0);
    chk("t5_int_b", 32'(INT_B), 32'h1);
    @(negedge CLK); RST_B = 1'b1;
    repeat (4) @(posedge CLK); #1;
    chk("t5_par_rel", 32'(PAR_RST), 32'h0);
    chk_en = 1'b1;
    host_cycle(1'b1, 3'd1, 8'h00, rd);
    chk("t5_hold_cleared", 32'(rd), 32'h00);

    // RESET while PHI2 is high in a host write: nothing enters H2P
    @(negedge CLK);
    CS_B = 1'b0; ADR = 3'd5; RNW_B = 1'b0; PHI2 = 1'b1; den = 1'b1; dout = 8'h3C;
    @(posedge CLK); #1;
    chk_en = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;
    model_clear();
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK); PHI2 = 1'b0; den = 1'b0;
    repeat (6) @(posedge CLK); #1;
    chk("t6_avail", 32'(H2P_AVAIL), 32'h0);
    chk("t6_h2p_data", H2P_DATA, 32'h0);
    chk("t6_overrun", 32'(OVERRUN), 32'h0);
    @(negedge CLK); CS_B = 1'b1; RNW_B = 1'b1;
    @(posedge CLK); #1;
    chk_en = 1'b1;
    host_cycle(1'b0, 3'd5, 8'hC3, rd);
    chk("t6_after", 32'(H2P_DATA[23:16]), 32'hC3);
    repeat (3) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
